// File: rtl/secded_mem_engine.sv
// secded_mem_engine: Hamming SECDED engine acting as a byte-wide memory-bus master.
// On req it walks NUM_WORDS little-endian words from SRC_BASE, encodes (mode=0)
// or decodes/corrects (mode=1) each one and writes the result to DST_BASE.
// Ports:
//   clk, reset (async, active low)
//   req, mode          : start request / 0=encode 1=decode (latched at start)
//   mem_addr, mem_wr_en, mem_wdata, mem_rdata : memory bus, combinational read
//   busy, done         : run status
//   sgl_cnt, dbl_cnt   : saturating single/double error counts of the last decode run
module secded_mem_engine #(
  parameter int DATA_W    = 11,
  parameter int NUM_WORDS = 15,
  parameter int SRC_BASE  = 30,
  parameter int DST_BASE  = 0,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              mode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [7:0]        sgl_cnt,
  output logic [7:0]        dbl_cnt
);

  localparam int PAR_W  = (DATA_W == 4) ? 3 : (DATA_W == 11) ? 4 : 5;
  localparam int CODE_W = 1 << PAR_W;
  localparam int BYTES  = CODE_W / 8;
  localparam logic [1:0] K_LAST = 2'(BYTES - 1);
  localparam logic [7:0] W_LAST = 8'(NUM_WORDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_PROC, S_WR, S_DONE} state_t;

  state_t            state;
  logic              mode_q;
  logic [7:0]        w;
  logic [1:0]        k;
  logic [CODE_W-1:0] word_q;
  logic [CODE_W-1:0] res_q;

  // Encoder: data bits fill the non-power-of-two positions from 3 upward,
  // then each Hamming bit covers positions with its index bit set, then p0.
  logic [CODE_W-1:0] enc;
  always_comb begin
    int  eidx;
    logic p;
    enc  = '0;
    eidx = 0;
    p    = 1'b0;
    for (int i = 1; i < CODE_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        enc[i] = word_q[eidx];
        eidx++;
      end
    end
    for (int j = 0; j < PAR_W; j++) begin
      p = 1'b0;
      for (int i = 1; i < CODE_W; i++)
        if (i[j]) p ^= enc[i];
      enc[1 << j] = p;
    end
    enc[0] = ^enc[CODE_W-1:1];
  end

  // Decoder: syndrome picks the bit to flip when overall parity is odd;
  // s=0 with odd parity lands on p0, which is harmless to flip.
  logic [PAR_W-1:0]  syn;
  logic              ov;
  logic [CODE_W-1:0] cor;
  logic [DATA_W-1:0] dec_data;
  logic [CODE_W-1:0] dec;
  always_comb begin
    int didx;
    syn = '0;
    for (int i = 1; i < CODE_W; i++)
      if (word_q[i]) syn ^= i[PAR_W-1:0];
    ov  = ^word_q;
    cor = word_q;
    if (ov) cor[syn] = ~word_q[syn];
    dec_data = '0;
    didx     = 0;
    for (int i = 1; i < CODE_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        dec_data[didx] = cor[i];
        didx++;
      end
    end
    dec               = '0;
    dec[DATA_W-1:0]   = dec_data;
    dec[CODE_W-1]     = ~ov & (syn != '0);
    dec[CODE_W-2]     = ov;
  end

  logic [CODE_W-1:0] result;
  logic              sgl_hit, dbl_hit;
  assign result  = mode_q ? dec : enc;
  assign sgl_hit = mode_q & ov;
  assign dbl_hit = mode_q & ~ov & (syn != '0);

  function automatic logic [ADDR_W-1:0] addr_of(input int base, input logic [7:0] wi,
                                                input logic [1:0] ki);
    return ADDR_W'(base + BYTES * int'(wi) + int'(ki));
  endfunction

  // Bus outputs are registered, so every transition loads the address/data
  // the next state needs in its first cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      mode_q    <= 1'b0;
      w         <= '0;
      k         <= '0;
      word_q    <= '0;
      res_q     <= '0;
      mem_addr  <= '0;
      mem_wr_en <= 1'b0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sgl_cnt   <= '0;
      dbl_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (req) begin
            mode_q   <= mode;
            w        <= '0;
            k        <= '0;
            sgl_cnt  <= '0;
            dbl_cnt  <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            mem_addr <= addr_of(SRC_BASE, 8'd0, 2'd0);
            state    <= S_RD;
          end
        end
        S_RD: begin
          word_q[8*k +: 8] <= mem_rdata;
          if (k == K_LAST) begin
            k        <= '0;
            mem_addr <= '0;
            state    <= S_PROC;
          end else begin
            k        <= k + 2'd1;
            mem_addr <= addr_of(SRC_BASE, w, k + 2'd1);
          end
        end
        S_PROC: begin
          res_q     <= result;
          if (sgl_hit && sgl_cnt != 8'hFF) sgl_cnt <= sgl_cnt + 8'd1;
          if (dbl_hit && dbl_cnt != 8'hFF) dbl_cnt <= dbl_cnt + 8'd1;
          k         <= '0;
          mem_wr_en <= 1'b1;
          mem_addr  <= addr_of(DST_BASE, w, 2'd0);
          mem_wdata <= result[7:0];
          state     <= S_WR;
        end
        S_WR: begin
          if (k == K_LAST) begin
            k         <= '0;
            mem_wr_en <= 1'b0;
            mem_wdata <= '0;
            if (w == W_LAST) begin
              mem_addr <= '0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= S_DONE;
            end else begin
              w        <= w + 8'd1;
              mem_addr <= addr_of(SRC_BASE, w + 8'd1, 2'd0);
              state    <= S_RD;
            end
          end else begin
            k         <= k + 2'd1;
            mem_addr  <= addr_of(DST_BASE, w, k + 2'd1);
            mem_wdata <= res_q[8*int'(k + 2'd1) +: 8];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_secded_mem_engine.sv
// tb_secded_mem_engine: randomized self-checking bench for secded_mem_engine.
// Four instances with their own byte memories:
//   0: DATA_W=11, 1 word      1: defaults (DATA_W=11, 15 words)
//   2: DATA_W=4, 6 words      3: DATA_W=26, 5 words, destination wraps past 255
module tb_secded_mem_engine;

  localparam int NI = 4;

  logic clk = 1'b0;
  logic reset;
  logic [NI-1:0]      req, mode, wr_en, busy, done;
  logic [NI-1:0][7:0] addr, wdata, rdata, sgl, dbl;
  logic [7:0]         mem [NI*256];
  logic [31:0]        exp_w [256];
  int total = 0, bad = 0, wr_seen = 0, nsgl, ndbl, cyc;

  always #5 clk = ~clk;

  secded_mem_engine #(.DATA_W(11), .NUM_WORDS(1), .SRC_BASE(30), .DST_BASE(0), .ADDR_W(8)) u_one (
    .clk(clk), .reset(reset), .req(req[0]), .mode(mode[0]), .mem_addr(addr[0]),
    .mem_wr_en(wr_en[0]), .mem_wdata(wdata[0]), .mem_rdata(rdata[0]), .busy(busy[0]),
    .done(done[0]), .sgl_cnt(sgl[0]), .dbl_cnt(dbl[0]));
  secded_mem_engine u_def (
    .clk(clk), .reset(reset), .req(req[1]), .mode(mode[1]), .mem_addr(addr[1]),
    .mem_wr_en(wr_en[1]), .mem_wdata(wdata[1]), .mem_rdata(rdata[1]), .busy(busy[1]),
    .done(done[1]), .sgl_cnt(sgl[1]), .dbl_cnt(dbl[1]));
  secded_mem_engine #(.DATA_W(4), .NUM_WORDS(6), .SRC_BASE(100), .DST_BASE(200), .ADDR_W(8)) u_w4 (
    .clk(clk), .reset(reset), .req(req[2]), .mode(mode[2]), .mem_addr(addr[2]),
    .mem_wr_en(wr_en[2]), .mem_wdata(wdata[2]), .mem_rdata(rdata[2]), .busy(busy[2]),
    .done(done[2]), .sgl_cnt(sgl[2]), .dbl_cnt(dbl[2]));
  secded_mem_engine #(.DATA_W(26), .NUM_WORDS(5), .SRC_BASE(40), .DST_BASE(250), .ADDR_W(8)) u_w26 (
    .clk(clk), .reset(reset), .req(req[3]), .mode(mode[3]), .mem_addr(addr[3]),
    .mem_wr_en(wr_en[3]), .mem_wdata(wdata[3]), .mem_rdata(rdata[3]), .busy(busy[3]),
    .done(done[3]), .sgl_cnt(sgl[3]), .dbl_cnt(dbl[3]));

  for (genvar g = 0; g < NI; g++) begin : g_rd
    assign rdata[g] = mem[g*256 + int'(addr[g])];
  end

  always @(posedge clk)
    for (int g = 0; g < NI; g++)
      if (wr_en[g]) begin
        mem[g*256 + int'(addr[g])] = wdata[g];
        if (g == 1) wr_seen++;
      end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int cw_of(input int dw);
    return (dw == 4) ? 8 : (dw == 11) ? 16 : 32;
  endfunction

  function automatic bit is_pow2(input int p);
    return (p & (p - 1)) == 0;
  endfunction

  function automatic logic [31:0] ref_enc(input int dw, input logic [31:0] d);
    logic [31:0] c;
    int cw, n, ones;
    cw = cw_of(dw); c = '0; n = 0;
    for (int p = 1; p < cw; p++)
      if (!is_pow2(p)) begin c[p] = d[n]; n++; end
    for (int j = 1; j < cw; j = j * 2) begin
      ones = 0;
      for (int p = 1; p < cw; p++) if ((p & j) != 0 && c[p]) ones++;
      c[j] = ones[0];
    end
    ones = $countones(c);
    c[0] = ones[0];
    return c;
  endfunction

  function automatic logic [31:0] extract(input int dw, input logic [31:0] c);
    logic [31:0] d;
    int n;
    d = '0; n = 0;
    for (int p = 1; p < cw_of(dw); p++)
      if (!is_pow2(p)) begin d[n] = c[p]; n++; end
    return d;
  endfunction

  function automatic int ma(input int g, input int base, input int bytes, input int w, input int k);
    return g*256 + ((base + bytes*w + k) % 256);
  endfunction

  task automatic put_word(input int g, input int base, input int bytes, input int w, input logic [31:0] v);
    for (int k = 0; k < bytes; k++) mem[ma(g, base, bytes, w, k)] = v[8*k +: 8];
  endtask

  function automatic logic [31:0] get_word(input int g, input int base, input int bytes, input int w);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < bytes; k++) v[8*k +: 8] = mem[ma(g, base, bytes, w, k)];
    return v;
  endfunction

  task automatic clear_dst(input int g, input int base, input int n);
    for (int i = 0; i < n; i++) mem[g*256 + ((base + i) % 256)] = 8'hEE;
  endtask

  // Random DATA_W=11 words with 0/1/2 injected flips; expectation follows from
  // what was injected, not from decoding the corrupted word.
  task automatic gen_dec(input int g, input int src, input int nw);
    nsgl = 0; ndbl = 0;
    for (int w = 0; w < nw; w++) begin
      logic [31:0] d, c, e;
      int nf, p1, p2;
      d  = $urandom & 32'h7FF;
      c  = ref_enc(11, d);
      nf = $urandom_range(0, 2);
      p1 = $urandom_range(0, 15);
      p2 = (p1 + $urandom_range(1, 15)) % 16;
      if (nf >= 1) c[p1] = ~c[p1];
      if (nf == 2) c[p2] = ~c[p2];
      e = d;
      if (nf == 1) begin e[14] = 1'b1; nsgl++; end
      if (nf == 2) begin e = extract(11, c); e[15] = 1'b1; ndbl++; end
      exp_w[w] = e;
      put_word(g, src, 2, w, c);
    end
  endtask

  task automatic gen_enc(input int g, input int dw, input int src, input int nw);
    for (int w = 0; w < nw; w++) begin
      logic [31:0] raw;
      raw = $urandom;             // upper bits beyond DATA_W must be ignored
      exp_w[w] = ref_enc(dw, raw);
      put_word(g, src, cw_of(dw) / 8, w, raw);
    end
  endtask

  task automatic check_words(input string tag, input int g, input int dst, input int bytes, input int nw);
    for (int w = 0; w < nw; w++)
      chk($sformatf("%s_w%0d", tag, w), get_word(g, dst, bytes, w), exp_w[w]);
  endtask

  // Start a run and wait for done (bounded). mode is flipped right after the
  // start edge and req may be pulsed mid-run; neither may disturb the run.
  task automatic run(input int g, input bit md, input bit pulse, input int abort_at, output int n);
    @(negedge clk);
    req[g] = 1'b1; mode[g] = md;
    @(posedge clk); #1;
    req[g] = 1'b0; mode[g] = ~md;
    chk($sformatf("busy_start%0d", g), busy[g], 1'b1);
    n = 0;
    while (!done[g] && n < 2000) begin
      @(posedge clk); #1;
      n++;
      req[g] = pulse && (n == 30 || n == 31);
      if (abort_at != 0 && n == abort_at) begin
        #2 reset = 1'b0;
        wr_seen = 0;
        return;
      end
    end
    req[g] = 1'b0;
    chk($sformatf("done%0d", g), done[g], 1'b1);
    chk($sformatf("busy_end%0d", g), busy[g], 1'b0);
  endtask

  initial begin
    reset = 1'b1; req = '0; mode = '0;
    for (int i = 0; i < NI*256; i++) mem[i] = 8'h00;
    #2 reset = 1'b0;
    #10;
    for (int g = 0; g < NI; g++)
      chk($sformatf("rst_state%0d", g), {addr[g], wr_en[g], wdata[g], busy[g], done[g], sgl[g], dbl[g]}, 64'd0);
    @(negedge clk) reset = 1'b1;

    // directed encode, single word
    put_word(0, 30, 2, 0, 32'h05A5);
    run(0, 1'b0, 1'b0, 0, cyc);
    chk("enc_cycles", cyc, 5);
    chk("enc_lo", mem[0], 8'h4B);
    chk("enc_hi", mem[1], 8'hB4);
    put_word(0, 30, 2, 0, 32'hF5A5);
    clear_dst(0, 0, 2);
    run(0, 1'b0, 1'b0, 0, cyc);
    chk("enc_upper_ignored", get_word(0, 0, 2, 0), 32'hB44B);

    // directed decode on the default instance
    for (int w = 0; w < 15; w++) begin put_word(1, 30, 2, w, 32'hB44B); exp_w[w] = 32'h05A5; end
    put_word(1, 30, 2, 1, 32'hB40B); exp_w[1] = 32'h45A5;
    put_word(1, 30, 2, 2, 32'hB44A); exp_w[2] = 32'h45A5;
    put_word(1, 30, 2, 3, 32'hB60B); exp_w[3] = extract(11, 32'hB60B) | 32'h8000;
    clear_dst(1, 0, 30);
    run(1, 1'b1, 1'b0, 0, cyc);
    chk("dec_dir_cycles", cyc, 75);
    check_words("dec_dir", 1, 0, 2, 15);
    chk("dbl_flags", get_word(1, 0, 2, 3) >> 14, 32'h2);
    chk("dec_dir_sgl", sgl[1], 8'd2);
    chk("dec_dir_dbl", dbl[1], 8'd1);

    // random decode runs with stray req pulses and a mode flip
    for (int r = 0; r < 2; r++) begin
      gen_dec(1, 30, 15);
      clear_dst(1, 0, 30);
      run(1, 1'b1, 1'b1, 0, cyc);
      chk("dec_rnd_cycles", cyc, 75);
      check_words("dec_rnd", 1, 0, 2, 15);
      chk("dec_rnd_sgl", sgl[1], nsgl);
      chk("dec_rnd_dbl", dbl[1], ndbl);
    end

    // random encode on every width
    gen_enc(1, 11, 30, 15); clear_dst(1, 0, 30);
    run(1, 1'b0, 1'b1, 0, cyc);
    check_words("enc11", 1, 0, 2, 15);
    chk("enc11_sgl", sgl[1], 8'd0);
    gen_enc(2, 4, 100, 6); clear_dst(2, 200, 6);
    run(2, 1'b0, 1'b0, 0, cyc);
    chk("enc4_cycles", cyc, 18);
    check_words("enc4", 2, 200, 1, 6);
    gen_enc(3, 26, 40, 5); clear_dst(3, 250, 20);
    run(3, 1'b0, 1'b0, 0, cyc);
    chk("enc26_cycles", cyc, 45);
    check_words("enc26", 3, 250, 4, 5);

    // reset mid-run, then a clean rerun
    gen_dec(1, 30, 15);
    clear_dst(1, 0, 30);
    run(1, 1'b1, 1'b0, 20, cyc);
    #1;
    chk("abort_outputs", {addr[1], wr_en[1], wdata[1], busy[1], done[1], sgl[1], dbl[1]}, 64'd0);
    check_words("abort_kept", 1, 0, 2, 4);
    chk("abort_unwritten", get_word(1, 0, 2, 4), 32'hEEEE);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (10) @(posedge clk);
    #1 chk("no_wr_after_rst", wr_seen, 0);
    run(1, 1'b1, 1'b0, 0, cyc);
    chk("rerun_cycles", cyc, 75);
    check_words("rerun", 1, 0, 2, 15);
    chk("rerun_sgl", sgl[1], nsgl);
    chk("rerun_dbl", dbl[1], ndbl);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
